hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It is the successor to the fixed combinational stall decoder. It keeps a shifting scoreboard of in-flight register writers, from EX through writeback. From that scoreboard it produces:
- ID stall and EX bubble;
- EX-stage forwarding selects;
- branch flush;
- multi-cycle EX busy hold;
- a stall performance counter.

It sits beside the ID/EX pipeline registers and drives the PC enable, the IF/ID enable/flush and the ID/EX bubble.

---
 rtl/hazard_scoreboard.sv | 120 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for the in-order pipeline: a shifting scoreboard of
// in-flight writers (slot 0 = EX) drives stall, bubble, flush and EX forwarding selects.
module hazard_scoreboard #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_id_valid,
    input  logic [AW-1:0] i_id_rs1,
    input  logic [AW-1:0] i_id_rs2,
    input  logic [AW-1:0] i_id_rd,
    input  logic          i_id_regwren,
    input  logic          i_id_is_load,
    input  logic          i_ex_redirect,
    input  logic          i_ex_busy,
    output logic          o_stall,
    output logic          o_flush_id,
    output logic          o_bubble_ex,
    output logic [SW-1:0] o_fwd_a,
    output logic [SW-1:0] o_fwd_b,
    output logic [31:0]   o_stall_cnt
);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_wen;
    logic [DEPTH-1:0] r_ld;
    logic [AW-1:0]    r_rd [DEPTH];
    logic [AW-1:0]    r_ex_rs1;
    logic [AW-1:0]    r_ex_rs2;
    logic [31:0]      r_stall_cnt;

    logic [DEPTH-1:0] w_writes;
    logic             w_hazard;
    logic             w_stall;
    logic             w_bubble;
    logic             w_busy;
    logic [SW-1:0]    w_fwd_a;
    logic [SW-1:0]    w_fwd_b;

    // First slot index whose result may be consumed by the instruction entering EX.
    function automatic int ready_slot(input logic is_load);
        if (FWD_EN == 0) return DEPTH - 1;
        return is_load ? 1 + LOAD_LAT : 1;
    endfunction

    always_comb begin
        w_writes = '0;
        w_hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_writes[k] = r_vld[k] & r_wen[k] & (r_rd[k] != '0);
            if (w_writes[k] && (r_rd[k] == i_id_rs1 || r_rd[k] == i_id_rs2) &&
                (k + 1 < ready_slot(r_ld[k])))
                w_hazard = 1'b1;
        end
    end

    // Redirect wins over stall and busy; a busy coinciding with redirect is ignored.
    assign w_busy   = i_ex_busy & ~i_ex_redirect;
    assign w_stall  = i_id_valid & ~i_ex_redirect & (w_hazard | i_ex_busy);
    assign w_bubble = i_ex_redirect | (w_stall & ~i_ex_busy);

    // Downward scan so the youngest eligible writer (smallest slot) wins.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        if (FWD_EN != 0 && r_vld[0]) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (w_writes[k] && k >= ready_slot(r_ld[k])) begin
                    if (r_rd[k] == r_ex_rs1) w_fwd_a = SW'(k);
                    if (r_rd[k] == r_ex_rs2) w_fwd_b = SW'(k);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld       <= '0;
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 2; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_wen[k] <= r_wen[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            if (w_busy) begin
                // EX holds its multi-cycle op; MEM receives nothing behind it.
                r_vld[1] <= 1'b0;
            end else begin
                r_vld[1] <= r_vld[0];
                r_wen[1] <= r_wen[0];
                r_ld[1]  <= r_ld[0];
                r_rd[1]  <= r_rd[0];
                r_vld[0] <= i_id_valid & ~w_bubble;
                r_wen[0] <= i_id_regwren;
                r_ld[0]  <= i_id_is_load;
                r_rd[0]  <= i_id_rd;
                r_ex_rs1 <= i_id_rs1;
                r_ex_rs2 <= i_id_rs2;
            end
            if (w_stall && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall     = w_stall;
    assign o_flush_id  = i_ex_redirect;
    assign o_bubble_ex = w_bubble;
    assign o_fwd_a     = w_fwd_a;
    assign o_fwd_b     = w_fwd_b;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against an
// instruction-list model, on a forwarding instance and a no-forwarding instance.
module tb_hazard_scoreboard;

    localparam int AW       = 5;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int SW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] rs1, rs2, rd;
    logic          wen, ld, redir, busy;

    logic          d_stall, d_flush, d_bubble;
    logic [SW-1:0] d_fwd_a, d_fwd_b;
    logic [31:0]   d_cnt;
    logic          n_stall, n_flush, n_bubble;
    logic [SW-1:0] n_fwd_a, n_fwd_b;
    logic [31:0]   n_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rd(rd), .i_id_regwren(wen), .i_id_is_load(ld), .i_ex_redirect(redir),
        .i_ex_busy(busy), .o_stall(d_stall), .o_flush_id(d_flush), .o_bubble_ex(d_bubble),
        .o_fwd_a(d_fwd_a), .o_fwd_b(d_fwd_b), .o_stall_cnt(d_cnt)
    );

    hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(0)) u_nf (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_rd(rd), .i_id_regwren(wen), .i_id_is_load(ld), .i_ex_redirect(redir),
        .i_ex_busy(busy), .o_stall(n_stall), .o_flush_id(n_flush), .o_bubble_ex(n_bubble),
        .o_fwd_a(n_fwd_a), .o_fwd_b(n_fwd_b), .o_stall_cnt(n_cnt)
    );

    // Observed outputs indexed by forwarding mode (1 = u_dut, 0 = u_nf).
    logic          obs_stall[2], obs_flush[2], obs_bubble[2];
    logic [SW-1:0] obs_fwd_a[2], obs_fwd_b[2];
    logic [31:0]   obs_cnt[2];
    assign obs_stall[1] = d_stall;   assign obs_stall[0] = n_stall;
    assign obs_flush[1] = d_flush;   assign obs_flush[0] = n_flush;
    assign obs_bubble[1] = d_bubble; assign obs_bubble[0] = n_bubble;
    assign obs_fwd_a[1] = d_fwd_a;   assign obs_fwd_a[0] = n_fwd_a;
    assign obs_fwd_b[1] = d_fwd_b;   assign obs_fwd_b[0] = n_fwd_b;
    assign obs_cnt[1] = d_cnt;       assign obs_cnt[0] = n_cnt;

    // ---------------- reference model: list of in-flight instructions ----------------
    typedef struct {
        int            fw;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        bit            wen;
        bit            ld;
        int            pos;
    } rec_t;

    rec_t          mq[$];
    logic          exp_stall[2], exp_flush[2], exp_bubble[2];
    logic [SW-1:0] exp_fwd_a[2], exp_fwd_b[2];
    logic [31:0]   exp_cnt[2];

    function automatic int ready_of(input int fw, input bit is_ld);
        if (fw == 0) return DEPTH - 1;
        return is_ld ? 1 + LOAD_LAT : 1;
    endfunction

    task automatic model_eval();
        for (int f = 0; f < 2; f++) begin
            bit haz = 0;
            bit have_ex = 0;
            logic [AW-1:0] ex_rs1 = '0, ex_rs2 = '0;
            int best_a = 0, best_b = 0;
            foreach (mq[i]) begin
                if (mq[i].fw != f) continue;
                if (mq[i].wen && mq[i].rd != 0 && (mq[i].rd == rs1 || mq[i].rd == rs2) &&
                    mq[i].pos + 1 < ready_of(f, mq[i].ld))
                    haz = 1;
                if (mq[i].pos == 0) begin
                    have_ex = 1;
                    ex_rs1 = mq[i].rs1;
                    ex_rs2 = mq[i].rs2;
                end
            end
            if (have_ex && f == 1) begin
                foreach (mq[i]) begin
                    if (mq[i].fw != f || mq[i].pos < 1 || !mq[i].wen || mq[i].rd == 0) continue;
                    if (mq[i].pos < ready_of(f, mq[i].ld)) continue;
                    if (mq[i].rd == ex_rs1 && (best_a == 0 || mq[i].pos < best_a)) best_a = mq[i].pos;
                    if (mq[i].rd == ex_rs2 && (best_b == 0 || mq[i].pos < best_b)) best_b = mq[i].pos;
                end
            end
            exp_stall[f]  = id_valid && !redir && (haz || busy);
            exp_flush[f]  = redir;
            exp_bubble[f] = redir || (exp_stall[f] && !busy);
            exp_fwd_a[f]  = SW'(best_a);
            exp_fwd_b[f]  = SW'(best_b);
        end
    endtask

    task automatic model_clock();
        rec_t nq[$];
        bit   hold;
        if (rst) begin
            mq.delete();
            exp_cnt[0] = 0;
            exp_cnt[1] = 0;
            return;
        end
        hold = busy && !redir;
        foreach (mq[i]) begin
            rec_t r = mq[i];
            if (!(hold && r.pos == 0)) r.pos++;
            if (r.pos < DEPTH) nq.push_back(r);
        end
        for (int f = 0; f < 2; f++) begin
            if (exp_stall[f] && exp_cnt[f] != 32'hFFFF_FFFF) exp_cnt[f]++;
            if (!hold && id_valid && !exp_bubble[f])
                nq.push_back('{fw: f, rd: rd, rs1: rs1, rs2: rs2, wen: wen, ld: ld, pos: 0});
        end
        mq = nq;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input int s1, input int s2, input int d,
                         input bit w, input bit l, input bit rdr, input bit bsy);
        id_valid = v;
        rs1 = AW'(s1); rs2 = AW'(s2); rd = AW'(d);
        wen = w; ld = l; redir = rdr; busy = bsy;
        #1;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({d_stall, d_flush, d_bubble, d_fwd_a, d_fwd_b, d_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_fwd: stall=%b flush=%b bubble=%b fa=%0d fb=%0d cnt=%0d required all 0",
                     d_stall, d_flush, d_bubble, d_fwd_a, d_fwd_b, d_cnt);
        end
        n_checks++;
        if ({n_stall, n_flush, n_bubble, n_fwd_a, n_fwd_b, n_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_nofwd: stall=%b flush=%b bubble=%b cnt=%0d required all 0",
                     n_stall, n_flush, n_bubble, n_cnt);
        end
    endtask

    task automatic test_alu_forward();
        do_reset();
        drive(1, 1, 2, 5, 1, 0, 0, 0);
        n_checks++;
        if (d_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall_add: got %b want 0", d_stall); end
        tick();
        drive(1, 5, 3, 6, 1, 0, 0, 0);
        n_checks++;
        if (d_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall_sub: got %b want 0", d_stall); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (d_fwd_a !== 2'd1) begin n_fail++; $display("FAIL alu_fwd_a: got %0d want 1", d_fwd_a); end
        n_checks++;
        if (d_fwd_b !== 2'd0) begin n_fail++; $display("FAIL alu_fwd_b: got %0d want 0", d_fwd_b); end
        n_checks++;
        if (d_cnt !== 32'd0) begin n_fail++; $display("FAIL alu_cnt: got %0d want 0", d_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 1, 0, 5, 1, 1, 0, 0);
        tick();
        drive(1, 5, 5, 6, 1, 0, 0, 0);
        n_checks++;
        if ({d_stall, d_bubble} !== 2'b11) begin
            n_fail++; $display("FAIL lu_stall1: stall=%b bubble=%b want 1 1", d_stall, d_bubble);
        end
        tick();
        n_checks++;
        if ({d_stall, d_bubble} !== 2'b00) begin
            n_fail++; $display("FAIL lu_stall2: stall=%b bubble=%b want 0 0", d_stall, d_bubble);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({d_fwd_a, d_fwd_b} !== {2'd2, 2'd2}) begin
            n_fail++; $display("FAIL lu_fwd: fa=%0d fb=%0d want 2 2", d_fwd_a, d_fwd_b);
        end
        n_checks++;
        if (d_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", d_cnt); end
    endtask

    task automatic test_no_forward();
        int stalls = 0, want = 0;
        do_reset();
        drive(1, 1, 2, 5, 1, 0, 0, 0);
        tick();
        drive(1, 5, 0, 7, 1, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            model_eval();
            if (exp_stall[0]) want++;
            if (n_stall) stalls++;
            if (!n_stall && !exp_stall[0]) break;
            tick();
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stalls !== want || stalls == 0) begin
            n_fail++; $display("FAIL nf_stalls: got %0d want %0d", stalls, want);
        end
        n_checks++;
        if (n_fwd_a !== 2'd0) begin n_fail++; $display("FAIL nf_fwd_a: got %0d want 0", n_fwd_a); end
        n_checks++;
        if (n_cnt !== 32'(want)) begin n_fail++; $display("FAIL nf_cnt: got %0d want %0d", n_cnt, want); end
    endtask

    task automatic test_x0();
        do_reset();
        drive(1, 1, 2, 0, 1, 1, 0, 0);
        tick();
        drive(1, 0, 0, 6, 1, 0, 0, 0);
        n_checks++;
        if ({d_stall, n_stall} !== 2'b00) begin
            n_fail++; $display("FAIL x0_stall: fwd=%b nofwd=%b want 0 0", d_stall, n_stall);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if ({d_fwd_a, d_fwd_b} !== 4'd0) begin
            n_fail++; $display("FAIL x0_fwd: fa=%0d fb=%0d want 0 0", d_fwd_a, d_fwd_b);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1, 1, 0, 5, 1, 1, 0, 0);
        tick();
        drive(1, 5, 5, 6, 1, 0, 1, 0);
        n_checks++;
        if ({d_stall, d_flush, d_bubble} !== 3'b011) begin
            n_fail++; $display("FAIL redir_out: stall=%b flush=%b bubble=%b want 0 1 1", d_stall, d_flush, d_bubble);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (u_dut.r_vld[0] !== 1'b0) begin n_fail++; $display("FAIL redir_slot0: got %b want 0", u_dut.r_vld[0]); end
        n_checks++;
        if (d_cnt !== 32'd0) begin n_fail++; $display("FAIL redir_cnt: got %0d want 0", d_cnt); end
    endtask

    task automatic test_busy_reset();
        do_reset();
        drive(1, 1, 2, 5, 1, 0, 0, 0);
        tick();
        drive(1, 1, 2, 8, 1, 0, 0, 0);
        tick();
        drive(1, 3, 4, 9, 1, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({d_stall, d_bubble} !== 2'b10) begin
                n_fail++; $display("FAIL busy_out%0d: stall=%b bubble=%b want 1 0", c, d_stall, d_bubble);
            end
            tick();
            n_checks++;
            if (u_dut.r_vld[0] !== 1'b1 || u_dut.r_rd[0] !== 5'd8 || u_dut.r_vld[1] !== 1'b0) begin
                n_fail++; $display("FAIL busy_slots%0d: v0=%b rd0=%0d v1=%b want 1 8 0",
                                   c, u_dut.r_vld[0], u_dut.r_rd[0], u_dut.r_vld[1]);
            end
        end
        n_checks++;
        if (d_cnt !== 32'd3) begin n_fail++; $display("FAIL busy_cnt: got %0d want 3", d_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 3, 4, 9, 1, 0, 0, 0);
        n_checks++;
        if ({d_stall, d_cnt} !== 33'd0) begin
            n_fail++; $display("FAIL rst_mid_stall: stall=%b cnt=%0d want 0 0", d_stall, d_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bit b = ($urandom_range(0, 99) < 15);
            bit r = !b && ($urandom_range(0, 99) < 8);
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 80, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35, r, b);
            model_eval();
            for (int f = 0; f < 2; f++) begin
                n_checks++;
                if ({obs_stall[f], obs_flush[f], obs_bubble[f]} !== {exp_stall[f], exp_flush[f], exp_bubble[f]}) begin
                    n_fail++;
                    $display("FAIL rnd_ctl c=%0d fw=%0d: got %b%b%b want %b%b%b", c, f, obs_stall[f],
                             obs_flush[f], obs_bubble[f], exp_stall[f], exp_flush[f], exp_bubble[f]);
                end
                n_checks++;
                if ({obs_fwd_a[f], obs_fwd_b[f]} !== {exp_fwd_a[f], exp_fwd_b[f]}) begin
                    n_fail++;
                    $display("FAIL rnd_fwd c=%0d fw=%0d: got %0d %0d want %0d %0d", c, f,
                             obs_fwd_a[f], obs_fwd_b[f], exp_fwd_a[f], exp_fwd_b[f]);
                end
                n_checks++;
                if (obs_cnt[f] !== exp_cnt[f]) begin
                    n_fail++;
                    $display("FAIL rnd_cnt c=%0d fw=%0d: got %0d want %0d", c, f, obs_cnt[f], exp_cnt[f]);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_alu_forward();
        test_load_use();
        test_no_forward();
        test_x0();
        test_redirect();
        test_busy_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
